// File: rtl/ls_dma_engine.sv
`timescale 1ns/1ps
// ls_dma_engine: initiator side of the local store port.
// GET commands move quadwords from a valid/ready input stream into the local store;
// PUT commands read the local store (combinational read of LS_addr) and stream the
// quadwords out. One command runs at a time; busy/done/err report progress.
module ls_dma_engine #(
  parameter int LEN_W  = 8,
  parameter int ADDR_W = 15
) (
  input  logic              clk,
  input  logic              rst,          // asynchronous, active-low
  // command port
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_op,       // 0 = GET (stream -> LS), 1 = PUT (LS -> stream)
  input  logic [ADDR_W-1:0] cmd_ls_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  // GET data stream
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [0:127]      in_data,
  // PUT data stream
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:127]      out_data,
  // local store interface
  output logic              LS_write_en,
  output logic [ADDR_W-1:0] LS_addr,
  output logic [0:127]      LS_data_in,
  input  logic [0:127]      LS_data_out,
  // status
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GET      = 3'd1,
    S_PUT_RD   = 3'd2,
    S_PUT_SEND = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // One quadword step; wraps naturally modulo 2^ADDR_W.
  localparam logic [ADDR_W-1:0] QW_STEP = ADDR_W'(16);
  localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   cur_addr_reg, cur_addr_next;
  logic [LEN_W-1:0]    remaining_reg, remaining_next;
  logic                err_reg, err_next;
  logic [0:127]        out_data_reg, out_data_next;
  logic                misaligned;

  // Low nibble of a quadword address must be zero.
  assign misaligned = (cmd_ls_addr[3:0] != 4'd0);

  // State and datapath registers; reset aborts any command in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      cur_addr_reg  <= '0;
      remaining_reg <= '0;
      err_reg       <= 1'b0;
      out_data_reg  <= '0;
    end else begin
      state_reg     <= state_next;
      cur_addr_reg  <= cur_addr_next;
      remaining_reg <= remaining_next;
      err_reg       <= err_next;
      out_data_reg  <= out_data_next;
    end
  end

  // Next-state logic and all handshake/local-store outputs.
  always_comb begin
    state_next     = state_reg;
    cur_addr_next  = cur_addr_reg;
    remaining_next = remaining_reg;
    err_next       = err_reg;
    out_data_next  = out_data_reg;
    cmd_ready      = 1'b0;
    in_ready       = 1'b0;
    out_valid      = 1'b0;
    LS_write_en    = 1'b0;
    LS_data_in     = '0;
    done           = 1'b0;
    err            = 1'b0;

    case (state_reg)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_next  = cmd_ls_addr;
          remaining_next = cmd_len;
          err_next       = misaligned;
          if (misaligned || (cmd_len == '0)) begin
            state_next = S_DONE;
          end else if (cmd_op) begin
            state_next = S_PUT_RD;
          end else begin
            state_next = S_GET;
          end
        end
      end

      S_GET: begin
        in_ready   = 1'b1;
        // Write data path follows the stream directly so the store happens in the
        // handshake cycle itself.
        LS_data_in = in_data;
        if (in_valid) begin
          LS_write_en    = 1'b1;
          cur_addr_next  = cur_addr_reg + QW_STEP;
          remaining_next = remaining_reg - LEN_ONE;
          if (remaining_reg == LEN_ONE) begin
            state_next = S_DONE;
          end
        end
      end

      S_PUT_RD: begin
        // Capture the combinational read so out_data stays stable under stalls.
        out_data_next = LS_data_out;
        state_next    = S_PUT_SEND;
      end

      S_PUT_SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          cur_addr_next  = cur_addr_reg + QW_STEP;
          remaining_next = remaining_reg - LEN_ONE;
          if (remaining_reg == LEN_ONE) begin
            state_next = S_DONE;
          end else begin
            state_next = S_PUT_RD;
          end
        end
      end

      S_DONE: begin
        done       = 1'b1;
        err        = err_reg;
        state_next = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign LS_addr  = cur_addr_reg;
  assign out_data = out_data_reg;
  assign busy     = (state_reg != S_IDLE);

endmodule

// File: tb/tb_ls_dma_engine.sv
`timescale 1ns/1ps
// Testbench for ls_dma_engine: a table of directed commands plus randomized
// commands, checked against a quadword-level model of the local store.
module tb_ls_dma_engine;

  localparam int LEN_W  = 8;
  localparam int ADDR_W = 15;
  localparam int NQW    = 2048;

  logic              clk;
  logic              rst;
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_op;
  logic [ADDR_W-1:0] cmd_ls_addr;
  logic [LEN_W-1:0]  cmd_len;
  logic              in_valid;
  logic              in_ready;
  logic [0:127]      in_data;
  logic              out_valid;
  logic              out_ready;
  logic [0:127]      out_data;
  logic              LS_write_en;
  logic [ADDR_W-1:0] LS_addr;
  logic [0:127]      LS_data_in;
  logic [0:127]      LS_data_out;
  logic              busy;
  logic              done;
  logic              err;

  int vectors    = 0;
  int miscompares = 0;

  // Local store attached to the DUT, and the expected contents.
  logic [0:127] ls_mem  [NQW];
  logic [0:127] ref_mem [NQW];

  ls_dma_engine #(.LEN_W(LEN_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ls_addr(cmd_ls_addr), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .LS_write_en(LS_write_en), .LS_addr(LS_addr), .LS_data_in(LS_data_in),
    .LS_data_out(LS_data_out),
    .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (LS_write_en) ls_mem[LS_addr[14:4]] <= LS_data_in;
  end
  assign LS_data_out = ls_mem[LS_addr[14:4]];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [0:127] rand_qw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Byte address of quadword i of a transfer starting at base (mod 2^15).
  function automatic logic [14:0] qw_addr(input logic [14:0] base, input int i);
    int a;
    a = (int'(base) + 16 * i) % 32768;
    return a[14:0];
  endfunction

  typedef struct {
    bit          op;
    logic [14:0] addr;
    int          len;
    bit          stall;
    bit          exp_err;
    int          exp_lat;   // cycles from accept to done, -1 = not checked
  } vec_t;

  // Runs one command. Entered and left #1 after a rising edge.
  task automatic run_cmd(input vec_t v);
    logic [0:127] words[$];
    logic [0:127] held_data;
    int  wcnt = 0;
    int  ocnt = 0;
    int  cyc  = 0;
    int  budget;
    bit  seen = 0;
    bit  held = 0;
    bit  xfer;
    xfer   = !v.exp_err && (v.len != 0);
    budget = 40 + 10 * v.len;
    for (int i = 0; i < v.len; i++) words.push_back(rand_qw());

    cmd_valid   = 1'b1;
    cmd_op      = v.op;
    cmd_ls_addr = v.addr;
    cmd_len     = LEN_W'(v.len);
    @(negedge clk);
    check("cmd_ready_idle", cmd_ready, 1);
    check("busy_idle", busy, 0);
    @(posedge clk); #1;
    cmd_valid   = 1'b0;
    cmd_ls_addr = 15'($urandom);

    while (!seen && cyc < budget) begin
      in_valid  = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data   = (wcnt < v.len) ? words[wcnt] : rand_qw();
      out_ready = v.stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      @(negedge clk);
      if (done) seen = 1;
      check("we_vs_handshake", LS_write_en, in_ready && in_valid);
      if (LS_write_en) begin
        if (v.op || !xfer || wcnt >= v.len) begin
          check("unexpected_write", LS_write_en, 0);
        end else begin
          check("get_addr", LS_addr, qw_addr(v.addr, wcnt));
          check("get_data", LS_data_in, words[wcnt]);
        end
        wcnt++;
      end
      if (in_ready && (v.op || !xfer)) check("in_ready_outside_get", in_ready, 0);
      if (held) begin
        check("out_valid_hold", out_valid, 1);
        check("out_data_hold", out_data, held_data);
        held = 0;
      end
      if (out_valid) begin
        if (!v.op || !xfer || ocnt >= v.len) begin
          check("unexpected_out_valid", out_valid, 0);
        end else if (out_ready) begin
          check("put_data", out_data, ref_mem[qw_addr(v.addr, ocnt) >> 4]);
          ocnt++;
        end else begin
          held      = 1;
          held_data = out_data;
        end
      end
      if (!seen) begin
        @(posedge clk); #1;
        cyc++;
      end
    end

    check("done_seen", seen, 1);
    check("done_err", err, v.exp_err);
    check("write_count", wcnt, (xfer && !v.op) ? v.len : 0);
    check("out_count", ocnt, (xfer && v.op) ? v.len : 0);
    if (v.exp_lat >= 0) check("latency", cyc, v.exp_lat);
    $display("cmd op=%0d addr=%h len=%0d err=%0d cycles=%0d", v.op, v.addr, v.len, err, cyc);
    if (xfer && !v.op) begin
      for (int i = 0; i < v.len; i++) ref_mem[qw_addr(v.addr, i) >> 4] = words[i];
    end

    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("cmd_ready_after", cmd_ready, 1);
    @(posedge clk); #1;
  endtask

  vec_t tbl[10];

  initial begin
    logic [0:127] w[5];
    vec_t rv;
    int bad;

    for (int i = 0; i < NQW; i++) begin
      ls_mem[i]  = rand_qw();
      ref_mem[i] = ls_mem[i];
    end
    rst = 1'b0; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_ls_addr = '0; cmd_len = '0;
    in_valid = 1'b1; in_data = rand_qw(); out_ready = 1'b1;

    // Reset state, with stream inputs active to show they are ignored.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_we", LS_write_en, 0);
    check("rst_addr", LS_addr, 0);
    check("rst_out_data", out_data, 0);
    check("rst_ls_data_in", LS_data_in, 0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk); #1;

    // Directed table: {op, addr, len, stall, expected err, expected latency}.
    tbl[0] = '{1'b0, 15'h0100, 3,   1'b0, 1'b0, 3};
    tbl[1] = '{1'b1, 15'h0200, 2,   1'b1, 1'b0, -1};
    tbl[2] = '{1'b1, 15'h0200, 2,   1'b0, 1'b0, 4};
    tbl[3] = '{1'b0, 15'h7FF0, 2,   1'b0, 1'b0, 2};
    tbl[4] = '{1'b0, 15'h0104, 4,   1'b0, 1'b1, 0};
    tbl[5] = '{1'b1, 15'h0104, 4,   1'b0, 1'b1, 0};
    tbl[6] = '{1'b0, 15'h0400, 0,   1'b0, 1'b0, 0};
    tbl[7] = '{1'b1, 15'h0400, 0,   1'b0, 1'b0, 0};
    tbl[8] = '{1'b0, 15'h1000, 255, 1'b1, 1'b0, -1};
    tbl[9] = '{1'b1, 15'h7FE0, 4,   1'b0, 1'b0, 8};
    for (int i = 0; i < 10; i++) run_cmd(tbl[i]);

    // Reset during the third quadword of a five-quadword GET.
    for (int i = 0; i < 5; i++) w[i] = rand_qw();
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_ls_addr = 15'h0300; cmd_len = 8'd5;
    @(posedge clk); #1;
    cmd_valid = 1'b0; in_valid = 1'b1; in_data = w[0];
    @(posedge clk); #1; in_data = w[1];
    @(posedge clk); #1; in_data = w[2];
    @(negedge clk);
    check("rst_mid_we_before", LS_write_en, 1);
    check("rst_mid_addr_before", LS_addr, 15'h0320);
    #1 rst = 1'b0;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_cmd_ready", cmd_ready, 1);
    check("rst_mid_in_ready", in_ready, 0);
    check("rst_mid_we", LS_write_en, 0);
    check("rst_mid_addr", LS_addr, 0);
    check("rst_mid_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_no_done", done, 0);
    check("rst_mid_qw0", ls_mem[15'h0300 >> 4], w[0]);
    check("rst_mid_qw1", ls_mem[15'h0310 >> 4], w[1]);
    check("rst_mid_qw2_untouched", ls_mem[15'h0320 >> 4], ref_mem[15'h0320 >> 4]);
    ref_mem[15'h0300 >> 4] = w[0];
    ref_mem[15'h0310 >> 4] = w[1];
    @(posedge clk); #1;
    rv = '{1'b0, 15'h0300, 1, 1'b0, 1'b0, 1};
    run_cmd(rv);

    // Randomized commands, some misaligned, some near the top of the store.
    for (int i = 0; i < 40; i++) begin
      rv.op    = 1'($urandom_range(0, 1));
      rv.addr  = 15'($urandom);
      if ($urandom_range(0, 7) != 0) rv.addr[3:0] = 4'd0;
      if ($urandom_range(0, 5) == 0) rv.addr[14:8] = 7'h7F;
      rv.len     = $urandom_range(0, 12);
      rv.stall   = 1'b1;
      rv.exp_err = (rv.addr[3:0] != 4'd0);
      rv.exp_lat = -1;
      run_cmd(rv);
    end

    bad = 0;
    for (int i = 0; i < NQW; i++) if (ls_mem[i] !== ref_mem[i]) bad++;
    check("ls_contents", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
